// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: constants and state encoding shared by the SPI slave files.
//   BYTE_W            - bits per SPI transfer
//   CNT_W             - width of the in-byte bit counter
//   IDLE_BYTE_DEFAULT - byte sent when the CPU has nothing queued
//   state_t           - IDLE (deselected) / SHIFT (selected)
package spi_slave_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = $clog2(BYTE_W);

  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'hFF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_sync3.sv
// sync3: three-flop synchronizer for one asynchronous bit.
//   clk, resetq - system clock, async active-low reset
//   d           - asynchronous input
//   q_mid       - second stage (newer sample, used for edge detection)
//   q           - third stage (synchronized value)
// RST_VAL sets the level all stages take during reset.
module sync3 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetq,
  input  logic d,
  output logic q_mid,
  output logic q
);

  logic [2:0] stage;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) stage <= {3{RST_VAL}};
    else         stage <= {stage[1:0], d};
  end

  assign q_mid = stage[1];
  assign q     = stage[2];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, oversampled on clk, with a one-byte transmit
// holding register and a one-byte receive register for a CPU.
//   clk, resetq          - system clock, async active-low reset
//   sck, mosi, cs_n      - SPI pins from master (asynchronous)
//   miso, miso_oe        - SPI data out and pad enable
//   wr, tx_data          - CPU loads the next byte to send
//   rd                   - CPU acknowledges rx_data
//   rx_data, rx_valid    - last received byte, unread flag
//   tx_full, busy        - holding register occupied, chip selected
//   overrun, irq         - sticky lost-byte flag, one-clk completion pulse
// Build option: SPI_SLAVE_OVERRUN_EN enables the overrun flag; otherwise
// overrun is tied low.
//
// state | meaning
// IDLE  | cs_n high, miso disabled
// SHIFT | cs_n low, shifting bytes on sck edges
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic              wr,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              rd,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_full,
  output logic              busy,
  output logic              overrun,
  output logic              irq
);

  logic sck_mid, sck_s, cs_mid, cs_s, mosi_s, mosi_unused;

  sync3 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .resetq(resetq), .d(sck),  .q_mid(sck_mid),     .q(sck_s));
  sync3 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .resetq(resetq), .d(cs_n), .q_mid(cs_mid),      .q(cs_s));
  sync3 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .resetq(resetq), .d(mosi), .q_mid(mosi_unused), .q(mosi_s));

  logic sck_rise, sck_fall, cs_fall, cs_rise;
  assign sck_rise = sck_mid & ~sck_s;
  assign sck_fall = ~sck_mid & sck_s;
  assign cs_fall  = ~cs_mid & cs_s;
  assign cs_rise  = cs_mid & ~cs_s;

  state_t            state, state_n;
  logic [CNT_W-1:0]  bitcnt, bitcnt_n;
  logic [BYTE_W-1:0] tx_sr, tx_sr_n, rx_sr, rx_sr_n;
  logic [BYTE_W-1:0] tx_hold, tx_hold_n, rx_data_n;
  logic              rx_valid_n, tx_full_n, irq_n;
  logic              load, done;

  always_comb begin
    state_n    = state;
    bitcnt_n   = bitcnt;
    tx_sr_n    = tx_sr;
    rx_sr_n    = rx_sr;
    rx_data_n  = rx_data;
    rx_valid_n = rx_valid;
    tx_full_n  = tx_full;
    tx_hold_n  = tx_hold;
    irq_n      = 1'b0;
    load       = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n  = SHIFT;
          bitcnt_n = '0;
          load     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n  = IDLE;
          bitcnt_n = '0;
          rx_sr_n  = '0;
        end else if (sck_rise) begin
          rx_sr_n  = {rx_sr[BYTE_W-2:0], mosi_s};
          bitcnt_n = bitcnt + 1'b1;
          done     = (bitcnt == CNT_W'(BYTE_W - 1));
        end else if (sck_fall) begin
          // bitcnt==0 on a fall means a byte just finished: queue the next one
          if (bitcnt != '0) tx_sr_n = {tx_sr[BYTE_W-2:0], 1'b0};
          else              load    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      tx_sr_n   = tx_full ? tx_hold : IDLE_BYTE;
      tx_full_n = 1'b0;
    end

    // completion beats a coincident rd so the new byte is never lost
    if (done) begin
      rx_data_n  = {rx_sr[BYTE_W-2:0], mosi_s};
      rx_valid_n = 1'b1;
      irq_n      = 1'b1;
    end else if (rd) begin
      rx_valid_n = 1'b0;
    end

    // a write in the same clk as a load refills the holding register
    if (wr) begin
      tx_hold_n = tx_data;
      tx_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state    <= IDLE;
      bitcnt   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      tx_hold  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_full  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state    <= state_n;
      bitcnt   <= bitcnt_n;
      tx_sr    <= tx_sr_n;
      rx_sr    <= rx_sr_n;
      tx_hold  <= tx_hold_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_full  <= tx_full_n;
      irq      <= irq_n;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)              overrun_q <= 1'b0;
    else if (rd)              overrun_q <= 1'b0;
    else if (done & rx_valid) overrun_q <= 1'b1;
  end
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  assign miso    = tx_sr[BYTE_W-1];
  assign miso_oe = (state == SHIFT);
  assign busy    = ~cs_s;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk = 1'b0, resetq = 1'b0;
  logic       sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_oe, rx_valid, tx_full, busy, overrun, irq;
  logic [7:0] rx_data;

  spi_slave dut (
    .clk(clk), .resetq(resetq), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .wr(wr), .tx_data(tx_data), .rd(rd),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_full(tx_full), .busy(busy),
    .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  int errors = 0, checks = 0;
  int irq_cnt = 0;
  always @(posedge clk) if (irq) irq_cnt <= irq_cnt + 1;

  // reference model: byte-level view of the CPU side
  bit         m_pend, m_rx_valid, m_ovr;
  logic [7:0] m_hold, m_rx_data;

  logic [7:0] mo [4];
  logic [7:0] mi [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_load();
    logic [7:0] b;
    b = m_pend ? m_hold : 8'hFF;
    m_pend = 1'b0;
    return b;
  endfunction

  task automatic m_complete(input logic [7:0] b, input bit rd_co);
    if (rd_co) m_ovr = 1'b0;
    else if (m_rx_valid && OVR_EN) m_ovr = 1'b1;
    m_rx_data  = b;
    m_rx_valid = 1'b1;
  endtask

  task automatic m_reset();
    m_pend = 0; m_rx_valid = 0; m_ovr = 0; m_hold = 0; m_rx_data = 0;
  endtask

  task automatic cpu_wr(input logic [7:0] v);
    tx_data = v; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
    m_pend = 1'b1; m_hold = v;
  endtask

  task automatic cpu_rd();
    rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    m_rx_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // shifts nbits of b MSB first at f_clk/8; optional rd lands in the
  // clk where the final rise is detected (3 sync stages after sck rises)
  task automatic xfer_byte(input logic [7:0] b, input int nbits, input bit rd_last,
                           output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      got = {got[6:0], miso};
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        rd = rd_last && (i == 0) && (k == 1);
      end
      sck = 1'b0;
    end
  endtask

  task automatic frame(input int nfull, input int part_bits, input bit rd_last);
    logic [7:0] exp_mi [4];
    logic [7:0] dummy;
    int irq_base;
    irq_base = irq_cnt;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    exp_mi[0] = m_load();
    check("tx_full_after_cs_fall", tx_full, m_pend);
    for (int j = 0; j < nfull; j++) begin
      xfer_byte(mo[j], 8, rd_last && (j == nfull - 1), mi[j]);
      m_complete(mo[j], rd_last && (j == nfull - 1));
      if (j < 3) exp_mi[j+1] = m_load();
      else       dummy = m_load();
    end
    if (part_bits > 0) xfer_byte(mo[nfull], part_bits, 1'b0, dummy);
    repeat (4) @(negedge clk);
    check("busy_in_frame", busy, 1);
    check("miso_oe_in_frame", miso_oe, 1);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int j = 0; j < nfull; j++) check($sformatf("master_rx[%0d]", j), mi[j], exp_mi[j]);
    check("rx_data", rx_data, m_rx_data);
    check("rx_valid", rx_valid, m_rx_valid);
    check("tx_full", tx_full, m_pend);
    check("overrun", overrun, m_ovr);
    check("irq_count", irq_cnt - irq_base, nfull);
    check("busy_idle", busy, 0);
    check("miso_oe_idle", miso_oe, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_tx_full"}, tx_full, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_miso_oe"}, miso_oe, 0);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_irq"}, irq, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] dummy;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    resetq = 1'b1;
    repeat (3) @(negedge clk);

    // preloaded byte goes out, received byte lands in rx_data
    cpu_wr(8'hA5);
    check("tx_full_after_wr", tx_full, 1);
    mo[0] = 8'h3C; frame(1, 0, 0);

    // nothing queued: master sees the idle byte
    cpu_rd();
    mo[0] = 8'h12; frame(1, 0, 0);

    // two bytes without rd: second overwrites, overrun only if enabled
    cpu_rd();
    mo[0] = 8'h11; mo[1] = 8'h22; frame(2, 0, 0);
    cpu_rd();
    check("rx_valid_after_rd", rx_valid, 0);
    check("overrun_after_rd", overrun, 0);

    // aborted partial byte, then a full byte
    mo[0] = 8'hF0; frame(0, 5, 0);
    mo[0] = 8'h81; frame(1, 0, 0);

    // rd coinciding with completion (rx_valid already 1 beforehand)
    mo[0] = 8'h5A; frame(1, 0, 1);

    // second wr overwrites the pending byte
    cpu_wr(8'h33); cpu_wr(8'h44);
    mo[0] = 8'h9E; frame(1, 0, 0);

    // reset mid-transfer, then a normal transfer
    cpu_wr(8'h6B);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    xfer_byte(8'hC3, 4, 1'b0, dummy);
    resetq = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    cpu_wr(8'hD2);
    mo[0] = 8'h27; frame(1, 0, 0);

    // randomized frames
    for (int it = 0; it < 20; it++) begin
      int nwr, nfull, part;
      bit rdl;
      nwr = $urandom_range(0, 2);
      for (int w = 0; w < nwr; w++) cpu_wr(8'($urandom));
      nfull = $urandom_range(0, 3);
      part  = ($urandom_range(0, 3) == 0 || nfull == 0) ? $urandom_range(1, 7) : 0;
      rdl   = (nfull > 0) && ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 4; j++) mo[j] = 8'($urandom);
      frame(nfull, part, rdl);
      if ($urandom_range(0, 1) == 1) cpu_rd();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL provide parameter IDLE_BYTE, default 8'hFF: byte shifted out when no transmit byte is pending.
REQ-002 SHALL provide clk  input  1  system clock, all internal state on posedge clk.
REQ-003 SHALL provide resetq  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide sck  input  1  SPI clock from external master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-005 SHALL provide mosi  input  1  serial data from master, MSB first.
REQ-006 SHALL provide cs_n  input  1  chip select from master, active-low.
REQ-007 SHALL provide miso  output  1  serial data to master, MSB first.
REQ-008 SHALL provide miso_oe  output  1  output enable for the miso pad, high only while selected.
REQ-009 SHALL provide wr  input  1  CPU write strobe, one clk; loads tx_data into the transmit holding register.
REQ-010 SHALL provide tx_data  input  8  byte for the next transfer.
REQ-011 SHALL provide rd  input  1  CPU read strobe, one clk; acknowledges rx_data.
REQ-012 SHALL provide rx_data  output  8  last completed received byte.
REQ-013 SHALL provide rx_valid  output  1  unread byte present in rx_data.
REQ-014 SHALL provide tx_full  output  1  transmit holding register occupied.
REQ-015 SHALL provide busy  output  1  synchronized cs_n is low.
REQ-016 SHALL provide overrun  output  1  sticky: byte completed while rx_valid was already 1.
REQ-017 SHALL provide irq  output  1  one-clk pulse per completed byte.

Function
REQ-018 sck, mosi and cs_n SHALL each pass a 3-flop synchronizer; edges SHALL be detected on synchronized sck (rise: stage3=0, stage2=1); f_clk >= 8 x f_sck is required.
REQ-019 States SHALL be IDLE (cs_n high) and SHIFT (cs_n low); a 3-bit counter bitcnt SHALL track the position within the byte.
REQ-020 On synchronized cs_n fall: IDLE->SHIFT, bitcnt=0, tx shift register loaded from the holding register if tx_full (tx_full cleared same clk), else loaded with IDLE_BYTE.
REQ-021 miso SHALL equal tx shift register bit 7; miso_oe SHALL equal SHIFT.
REQ-022 On sck rise in SHIFT: rx shift register takes mosi at its LSB, bitcnt+1 (wraps 7->0).
REQ-023 On the rise that wraps bitcnt 7->0: rx_data=assembled byte, rx_valid=1 and irq=1 on the next clk.
REQ-024 On sck fall in SHIFT: bitcnt!=0 shifts tx left by one; bitcnt==0 reloads the next byte per REQ-020, clearing tx_full if used.
REQ-025 On cs_n rise mid-byte: SHIFT->IDLE, bitcnt=0, partial byte discarded, rx_valid/rx_data unchanged, no irq.
REQ-026 rd SHALL clear rx_valid; if rd coincides with byte completion, completion wins (rx_valid stays 1, no overrun).
REQ-027 wr while tx_full SHALL overwrite the pending byte; wr coinciding with a holding-register load SHALL leave tx_full=1 with the new byte.
REQ-028 Byte completion with rx_valid=1 and no coincident rd SHALL overwrite rx_data.

Reset
REQ-029 resetq low SHALL asynchronously force IDLE, bitcnt=0, shift registers=0, rx_data=0, rx_valid=0, tx_full=0, overrun=0, irq=0, busy=0, miso_oe=0, miso=0; synchronizer flops SHALL reset to idle levels (cs_n=1, sck=0).

Configuration
REQ-030 Macro SPI_SLAVE_OVERRUN_EN defined: overrun SHALL set per REQ-016 and clear only on rd.
REQ-031 Macro undefined: overrun SHALL be constant 0 and its logic absent; REQ-028 still applies.

Structure
REQ-032 A shared package SHALL hold the byte-width constant, the IDLE/SHIFT state encoding and the default IDLE_BYTE.
REQ-033 The 3-flop synchronizer SHALL be a sub-module sync3 (one bit, reset value parameter), instantiated three times.

Verification
REQ-034 Reset mid-transfer (cs_n low, 4 bits shifted) -> all outputs at REQ-029 values; the next full transfer works.
REQ-035 wr 0xA5, master sends 0x3C at f_clk/8 -> master reads 0xA5, rx_data=0x3C, rx_valid=1, single irq, tx_full 0 after cs_n fall.
REQ-036 No wr, master sends 0x12 -> master reads 0xFF, rx_data=0x12.
REQ-037 Two bytes 0x11,0x22 in one cs_n frame, no rd -> rx_data=0x22, overrun=1 with macro, 0 without; rd clears both flags.
REQ-038 cs_n high after 5 bits of 0xF0, then full byte 0x81 -> rx_valid 0 after abort, then rx_data=0x81 with one irq.
REQ-039 rd asserted in the completion clk of byte 0x5A -> rx_valid stays 1, rx_data=0x5A, overrun=0.
